mul_share_arbiter: RTL and testbench

//  Shares one 4x4 unsigned multiplier datapath among NREQ requesters.

---
 rtl/mul_share_arb_pkg.sv | 14 +
 rtl/mul_share_arbiter_if.sv | 27 ++
 rtl/mul_share_arbiter_rr_grant.sv | 34 +++
 rtl/mul_share_arbiter.sv | 109 ++++++++++
 tb/tb_mul_share_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mul_share_arb_pkg.sv
// rtl/mul_share_arb_pkg.sv - shared types and defaults for the multiplier-sharing arbiter
package mul_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NREQ_DEFAULT = 4;
  localparam int W_DEFAULT    = 4;
  localparam int ID_W         = $clog2(NREQ_DEFAULT);

endpackage

// File: rtl/mul_share_arbiter_if.sv
// rtl/mul_share_arbiter_if.sv - requester-side request/response bus of the multiplier-sharing arbiter
interface mul_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [2*W-1:0]    rsp_prod;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_prod, busy, grant_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_prod, busy, grant_id
  );
endinterface

// File: rtl/mul_share_arbiter_rr_grant.sv
// rtl/mul_share_arbiter_rr_grant.sv - combinational round-robin picker: first request at or after ptr
module rr_grant
  import mul_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IDW  = ID_W
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_o
);

  int   idx;
  logic found;

  always_comb begin
    idx      = 0;
    found    = 1'b0;
    gnt_id_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        gnt_id_o = IDW'(idx);
      end
    end
    any_o = found;
    gnt_o = found ? (NREQ'(1) << gnt_id_o) : '0;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin sharing of one registered W x W multiplier among NREQ requesters
// Optional op_count statistics port enabled by MUL_SHARE_ARB_STATS_EN.
module mul_share_arbiter
  import mul_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int W    = W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  mul_share_arbiter_if.slave bus
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [15:0] op_count
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gid_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [2*W-1:0]  prod_q;
  logic [NREQ-1:0] rsp_valid_q;
  logic            busy_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            gnt_any;
  logic            rsp_hs;
  logic [IDW-1:0]  ptr_d;

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .req_i    (bus.req_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .any_o    (gnt_any)
  );

  // Accept strobe is combinational so the handshake completes in the grant cycle; masked during reset.
  assign bus.req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_prod  = prod_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = gid_q;

  assign rsp_hs = (state_q == RESP) && bus.rsp_ready[gid_q];
  assign ptr_d  = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gid_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            a_q     <= bus.req_a[gnt_id*W +: W];
            b_q     <= bus.req_b[gnt_id*W +: W];
            gid_q   <= gnt_id;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          prod_q      <= {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
          rsp_valid_q <= NREQ'(1) << gid_q;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_cnt_q <= '0;
    end else if (rsp_hs) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed self-checking bench for mul_share_arbiter
module tb_mul_share_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_share_arbiter_if #(.NREQ(4), .W(4)) bus ();

`ifdef MUL_SHARE_ARB_STATS_EN
  logic [15:0] op_count;
  mul_share_arbiter #(.NREQ(4), .W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .op_count (op_count)
  );
`else
  mul_share_arbiter #(.NREQ(4), .W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp);
    int         n;
    logic [3:0] oh;
    oh = 4'(1 << id);
    @(negedge clk);
    bus.req_valid[id]      = 1'b1;
    bus.req_a[id*4 +: 4]   = a;
    bus.req_b[id*4 +: 4]   = b;
    #1 check("op_req_ready", bus.req_ready, oh);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    n = 0;
    while (bus.rsp_valid == 4'd0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("op_rsp_latency", n, 1);
    check("op_rsp_valid", bus.rsp_valid, oh);
    check("op_rsp_prod", bus.rsp_prod, exp);
    check("op_grant_id", bus.grant_id, id);
    bus.rsp_ready = 4'hF;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 4'h0;
    #1 check("op_idle_busy", bus.busy, 0);
    check("op_idle_rsp_valid", bus.rsp_valid, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int         seq[5];
    logic [3:0] exp_rdy;
    clk    = 1'b0;
    rst    = 1'b1;
    checks = 0;
    errors = 0;
    seq    = '{0, 1, 2, 3, 0};

    // 1: outputs held at zero under reset despite random stimulus
    repeat (4) begin
      bus.req_valid = 4'($urandom);
      bus.rsp_ready = 4'($urandom);
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      @(negedge clk);
    end
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_prod", bus.rsp_prod, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_grant_id", bus.grant_id, 0);
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    rst           = 1'b0;
    run_op(0, 4'd3, 4'd5, 8'd15);
    check("t1_prod_kept", bus.rsp_prod, 15);

    // 2: product corners on requester 2
    run_op(2, 4'd15, 4'd15, 8'd225);
    run_op(2, 4'd0, 4'd9, 8'd0);
    run_op(2, 4'd1, 4'd13, 8'd13);

    // 3: all requesters pending, rsp_ready tied high, ptr back to 0
    pulse_reset();
    @(negedge clk);
    bus.req_valid = 4'hF;
    bus.rsp_ready = 4'hF;
    for (int k = 0; k < 13; k++) begin
      exp_rdy = (k % 3 == 0) ? 4'(1 << seq[k/3]) : 4'd0;
      #1 check("rr_req_ready", bus.req_ready, exp_rdy);
      @(negedge clk);
    end
    bus.req_valid = 4'h0;
    @(negedge clk);
    @(negedge clk);
    #1 check("rr_done_busy", bus.busy, 0);
    bus.rsp_ready = 4'h0;

    // 4: response stall on requester 1 (ptr=1), non-owner rsp_ready ignored
    @(negedge clk);
    bus.req_valid = 4'b0011;
    bus.req_a     = 16'h0070;
    bus.req_b     = 16'h0060;
    bus.rsp_ready = 4'b1000;
    #1 check("stall_grant", bus.req_ready, 4'b0010);
    @(negedge clk);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_rsp_valid", bus.rsp_valid, 4'b0010);
      check("stall_rsp_prod", bus.rsp_prod, 42);
      check("stall_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 4'b0010;
    @(negedge clk);
    bus.rsp_ready = 4'b0000;
    #1 check("stall_released", bus.rsp_valid, 0);

    // 5: reset during CALC drops the operation and rewinds ptr
    @(negedge clk);
    bus.req_valid = 4'b0100;
    bus.req_a     = 16'h0200;
    bus.req_b     = 16'h0300;
    #1 check("abort_grant", bus.req_ready, 4'b0100);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_rsp_valid", bus.rsp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("abort_no_rsp", bus.rsp_valid, 0);
    end
    bus.req_valid = 4'hF;
    #1 check("abort_ptr0", bus.req_ready, 4'b0001);
    @(negedge clk);
    bus.req_valid = 4'h0;
    bus.rsp_ready = 4'hF;
    @(negedge clk);
    @(negedge clk);
    bus.rsp_ready = 4'h0;
    #1 check("abort_next_idle", bus.busy, 0);

`ifdef MUL_SHARE_ARB_STATS_EN
    // 6: completion counter and its wrap
    pulse_reset();
    for (int k = 0; k < 10; k++) run_op(k % 4, 4'd2, 4'd2, 8'd4);
    check("stats_count10", op_count, 10);
    @(negedge clk);
    force dut.op_cnt_q = 16'hFFFF;
    #1 release dut.op_cnt_q;
    check("stats_preload", op_count, 16'hFFFF);
    run_op(0, 4'd1, 4'd1, 8'd1);
    check("stats_wrap", op_count, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
